// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO: default word/pointer widths and depth helper.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 32;
    localparam int FIFO_ADDR_WIDTH = 10;

    // Number of words addressable by a pointer of the given width.
    function automatic int unsigned fifo_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read; swappable for a vendor RAM.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    // Write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sync_core.sv
// First-word-fall-through single-clock FIFO: pointer/count control around fifo_mem.
module fifo_sync_core
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wEn,
    input  logic [DATA_WIDTH-1:0] wData,
    input  logic                  rEn,
    output logic [DATA_WIDTH-1:0] rData,
    output logic                  empty,
    output logic                  full
);

    localparam logic [ADDR_WIDTH-1:0] C_PTR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   C_CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   C_CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   C_CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_empty;
    logic                  r_full;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [ADDR_WIDTH:0]   w_count_nxt;

    // Acceptance uses the registered flags so enables never reach the flags combinationally.
    assign w_wr_acc = wEn & ~r_full;
    assign w_rd_acc = rEn & ~r_empty;

    // Occupancy update: a simultaneous accepted read and write cancel out.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + C_CNT_ONE;
            2'b01:   w_count_nxt = r_count - C_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointer, count and flag registers; flags are registered copies of the next count decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= C_PTR_ZERO;
            r_rptr  <= C_PTR_ZERO;
            r_count <= C_CNT_ZERO;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + C_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + C_PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == C_CNT_ZERO);
            r_full  <= (w_count_nxt == C_CNT_FULL);
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wptr),
        .i_wdata (wData),
        .i_raddr (r_rptr),
        .o_rdata (rData)
    );

    assign empty = r_empty;
    assign full  = r_full;

endmodule

// File: tb/tb_fifo_sync_core.sv
// Directed and random checks of fifo_sync_core against a reference queue.
module tb_fifo_sync_core;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        wEn;
    logic [31:0] wData;
    logic        rEn;
    logic [31:0] rData;
    logic        empty;
    logic        full;

    int checks;
    int failures;
    logic [31:0] sb [$];

    fifo_sync_core #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (10)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wEn   (wEn),
        .wData (wData),
        .rEn   (rEn),
        .rData (rData),
        .empty (empty),
        .full  (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Update the reference queue for the current inputs, clock once, then compare outputs.
    task automatic step(input logic w, input logic [31:0] d, input logic r, input logic rs);
        bit acc_w;
        bit acc_r;
        wEn   = w;
        wData = d;
        rEn   = r;
        rst   = rs;
        acc_w = w && (sb.size() < DEPTH);
        acc_r = r && (sb.size() != 0);
        if (rs) begin
            sb.delete();
        end else begin
            if (acc_r) void'(sb.pop_front());
            if (acc_w) sb.push_back(d);
        end
        @(posedge clk);
        #1;
        chk("empty", {31'd0, empty}, {31'd0, sb.size() == 0});
        chk("full", {31'd0, full}, {31'd0, sb.size() == DEPTH});
        if (sb.size() != 0) chk("rdata_head", rData, sb[0]);
    endtask

    initial begin
        int wp;
        int rp;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        wEn      = 1'b0;
        rEn      = 1'b0;
        wData    = 32'd0;

        // Reset and idle
        step(1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        chk("reset_empty", {31'd0, empty}, 32'd1);
        chk("reset_full", {31'd0, full}, 32'd0);
        for (int i = 0; i < 10; i++) step(1'b0, 32'd0, 1'b0, 1'b0);

        // Single word
        step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("single_rdata", rData, 32'hDEADBEEF);
        chk("single_notempty", {31'd0, empty}, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        chk("single_popped", {31'd0, empty}, 32'd1);

        // Fill, overflow attempt, drain, underflow attempt
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        chk("fill_full", {31'd0, full}, 32'd1);
        step(1'b1, 32'h12345678, 1'b0, 1'b0);
        chk("overflow_full", {31'd0, full}, 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", rData, 32'(i));
            step(1'b0, 32'd0, 1'b1, 1'b0);
        end
        chk("drain_empty", {31'd0, empty}, 32'd1);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        chk("underflow_empty", {31'd0, empty}, 32'd1);

        // Simultaneous read+write at count 5, at full, at empty
        for (int i = 0; i < 5; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'h1FF, 1'b1, 1'b0);
        chk("simul5_head", rData, 32'h101);
        chk("simul5_count", sb.size(), 32'd5);
        while (sb.size() < DEPTH) step(1'b1, $urandom, 1'b0, 1'b0);
        chk("pre_simul_full", {31'd0, full}, 32'd1);
        step(1'b1, 32'hCAFE0001, 1'b1, 1'b0);
        chk("simul_full_flag", {31'd0, full}, 32'd0);
        chk("simul_full_count", sb.size(), 32'(DEPTH - 1));
        while (sb.size() != 0) step(1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b1, 32'hBEEF0002, 1'b1, 1'b0);
        chk("simul_empty_rdata", rData, 32'hBEEF0002);
        chk("simul_empty_flag", {31'd0, empty}, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b0);

        // Random bursts alternating write-heavy and read-heavy to exercise wrap and both flags
        for (int ph = 0; ph < 6; ph++) begin
            wp = (ph % 2 == 0) ? 50 : 25;
            rp = (ph % 2 == 0) ? 25 : 50;
            for (int c = 0; c < 4000; c++) begin
                step($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < rp, 1'b0);
            end
        end

        // Reset mid-stream
        while (sb.size() > 0) step(1'b0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        step(1'b1, 32'h55555555, 1'b1, 1'b1);
        chk("midrst_empty", {31'd0, empty}, 32'd1);
        chk("midrst_full", {31'd0, full}, 32'd0);
        rst = 1'b0;
        step(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
        chk("postrst_rdata", rData, 32'hA5A5A5A5);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        chk("postrst_empty", {31'd0, empty}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
